// File: rtl/link_pkg.sv
// Shared definitions for the HPS link master: link word field positions,
// buffer depth and controller state encoding.
package link_pkg;

    localparam int N_ELEM = 25;

    localparam int LO_A     = 0;
    localparam int LO_B     = 8;
    localparam int LO_OP    = 16;
    localparam int LO_SZ    = 19;
    localparam int LO_C     = 21;
    localparam int LO_SRST  = 29;
    localparam int LO_START = 30;
    localparam int LO_READY = 31;

    localparam int LI_DATA = 0;
    localparam int LI_ACK  = 31;

    localparam logic [3:0] S_IDLE    = 4'd0;
    localparam logic [3:0] S_SRST    = 4'd1;
    localparam logic [3:0] S_START   = 4'd2;
    localparam logic [3:0] S_W_SETUP = 4'd3;
    localparam logic [3:0] S_W_REQ   = 4'd4;
    localparam logic [3:0] S_W_REL   = 4'd5;
    localparam logic [3:0] S_PWAIT   = 4'd6;
    localparam logic [3:0] S_R_REQ   = 4'd7;
    localparam logic [3:0] S_R_REL   = 4'd8;
    localparam logic [3:0] S_FIN     = 4'd9;
    localparam logic [3:0] S_ERR     = 4'd10;

    // Operand entries are stored as {c, b, a}.
    function automatic logic [31:0] pack_wr(
        input logic [23:0] abc,
        input logic [2:0]  op,
        input logic [1:0]  sz,
        input logic        rdy
    );
        logic [31:0] w;
        w = '0;
        w[LO_A +: 8]  = abc[7:0];
        w[LO_B +: 8]  = abc[15:8];
        w[LO_C +: 8]  = abc[23:16];
        w[LO_OP +: 3] = op;
        w[LO_SZ +: 2] = sz;
        w[LO_READY]   = rdy;
        return w;
    endfunction

endpackage

// File: rtl/link_sync2.sv
// Two-flop synchronizer for the asynchronous responder ack.
module link_sync2 (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/hps_link_master.sv
// Link master: streams 25 operand triples to a responder over a ready/ack
// four-phase link, then reads back 25 result bytes (plus one discarded).
module hps_link_master
    import link_pkg::*;
#(
    parameter int PROC_WAIT   = 64,
    parameter int ACK_TIMEOUT = 1024,
    parameter int SRST_CYC    = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wr_en,
    input  logic [4:0]  wr_addr,
    input  logic [7:0]  wr_a,
    input  logic [7:0]  wr_b,
    input  logic [7:0]  wr_c,
    input  logic [2:0]  op_code,
    input  logic [1:0]  mat_size,
    input  logic        go,
    output logic        busy,
    output logic        done,
    output logic        err,
    input  logic [4:0]  rd_addr,
    output logic [7:0]  rd_data,
    output logic [31:0] link_out,
    input  logic [31:0] link_in
);

    localparam int CM1  = (ACK_TIMEOUT > PROC_WAIT) ? ACK_TIMEOUT : PROC_WAIT;
    localparam int CMAX = (CM1 > SRST_CYC) ? CM1 : SRST_CYC;
    localparam int CW   = $clog2(CMAX + 1);

    localparam logic [CW-1:0] SRST_LAST = CW'(SRST_CYC - 1);
    localparam logic [CW-1:0] PW_LAST   = CW'(PROC_WAIT - 1);
    localparam logic [CW-1:0] TO_LAST   = CW'(ACK_TIMEOUT - 1);
    localparam logic [4:0]    LAST_WR   = 5'(N_ELEM - 1);
    localparam logic [4:0]    LAST_RD   = 5'(N_ELEM);

    logic [3:0]    state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [4:0]    idx, idx_n;
    logic [2:0]    op_q, op_n;
    logic [1:0]    sz_q, sz_n;
    logic          busy_n, err_n;
    logic          cap;
    logic          ack_s;
    logic [23:0]   wr_ent;
    logic [31:0]   link_n;

    logic [23:0] ops [N_ELEM];
    logic [7:0]  res [N_ELEM];

    logic unused_link;
    assign unused_link = ^link_in[30:LI_DATA+8];

    link_sync2 u_ack_sync (
        .clk   (clk),
        .reset (reset),
        .d     (link_in[LI_ACK]),
        .q     (ack_s)
    );

    always_comb begin
        state_n = state;
        cnt_n   = cnt + CW'(1);
        idx_n   = idx;
        op_n    = op_q;
        sz_n    = sz_q;
        busy_n  = busy;
        err_n   = err;
        cap     = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (go) begin
                    op_n    = op_code;
                    sz_n    = mat_size;
                    err_n   = 1'b0;
                    idx_n   = '0;
                    busy_n  = 1'b1;
                    cnt_n   = '0;
                    state_n = S_SRST;
                end
            end
            S_SRST: begin
                if (cnt == SRST_LAST) begin
                    cnt_n   = '0;
                    state_n = S_START;
                end
            end
            S_START: begin
                if (cnt == SRST_LAST) begin
                    cnt_n   = '0;
                    state_n = S_W_SETUP;
                end
            end
            S_W_SETUP: begin
                cnt_n   = '0;
                state_n = S_W_REQ;
            end
            S_W_REQ: begin
                if (ack_s) begin
                    cnt_n   = '0;
                    state_n = S_W_REL;
                end else if (cnt == TO_LAST) begin
                    state_n = S_ERR;
                end
            end
            S_W_REL: begin
                if (!ack_s) begin
                    cnt_n = '0;
                    if (idx == LAST_WR) begin
                        idx_n   = '0;
                        state_n = S_PWAIT;
                    end else begin
                        idx_n   = idx + 5'd1;
                        state_n = S_W_SETUP;
                    end
                end else if (cnt == TO_LAST) begin
                    state_n = S_ERR;
                end
            end
            S_PWAIT: begin
                if (cnt == PW_LAST) begin
                    cnt_n   = '0;
                    state_n = S_R_REQ;
                end
            end
            S_R_REQ: begin
                if (ack_s) begin
                    cnt_n   = '0;
                    state_n = S_R_REL;
                end else if (cnt == TO_LAST) begin
                    state_n = S_ERR;
                end
            end
            S_R_REL: begin
                if (!ack_s) begin
                    cnt_n = '0;
                    cap   = (idx <= LAST_WR);
                    if (idx == LAST_RD) begin
                        state_n = S_FIN;
                    end else begin
                        idx_n   = idx + 5'd1;
                        state_n = S_R_REQ;
                    end
                end else if (cnt == TO_LAST) begin
                    state_n = S_ERR;
                end
            end
            S_FIN: begin
                busy_n  = 1'b0;
                state_n = S_IDLE;
            end
            S_ERR: begin
                err_n   = 1'b1;
                busy_n  = 1'b0;
                state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    // The link word is derived from the next state so the registered
    // output always matches the state the controller is in.
    always_comb begin
        link_n = '0;
        wr_ent = (idx_n <= LAST_WR) ? ops[idx_n] : '0;
        unique case (state_n)
            S_SRST:             link_n[LO_SRST]  = 1'b1;
            S_START:            link_n[LO_START] = 1'b1;
            S_W_SETUP, S_W_REL: link_n = pack_wr(wr_ent, op_n, sz_n, 1'b0);
            S_W_REQ:            link_n = pack_wr(wr_ent, op_n, sz_n, 1'b1);
            S_R_REQ:            link_n[LO_READY] = 1'b1;
            default:            link_n = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            cnt      <= '0;
            idx      <= '0;
            op_q     <= '0;
            sz_q     <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            link_out <= '0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            idx      <= idx_n;
            op_q     <= op_n;
            sz_q     <= sz_n;
            busy     <= busy_n;
            done     <= (state_n == S_FIN);
            err      <= err_n;
            link_out <= link_n;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en && !busy && (wr_addr <= LAST_WR))
            ops[wr_addr] <= {wr_c, wr_b, wr_a};
    end

    always_ff @(posedge clk) begin
        if (cap)
            res[idx] <= link_in[LI_DATA +: 8];
    end

    assign rd_data = (rd_addr <= LAST_WR) ? res[rd_addr] : '0;

endmodule

// File: tb/tb_hps_link_master.sv
// Directed bench for hps_link_master with a behavioural link responder.
module tb_hps_link_master;

    localparam int PW = 16;
    localparam int TO = 200;
    localparam int SC = 4;
    localparam int N  = 25;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        wr_en = 1'b0;
    logic [4:0]  wr_addr = '0;
    logic [7:0]  wr_a = '0, wr_b = '0, wr_c = '0;
    logic [2:0]  op_code = '0;
    logic [1:0]  mat_size = '0;
    logic        go = 1'b0;
    logic        busy, done, err;
    logic [4:0]  rd_addr = '0;
    logic [7:0]  rd_data;
    logic [31:0] link_out;
    logic [31:0] link_in = '0;

    always #5 clk = ~clk;

    hps_link_master #(
        .PROC_WAIT   (PW),
        .ACK_TIMEOUT (TO),
        .SRST_CYC    (SC)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_a     (wr_a),
        .wr_b     (wr_b),
        .wr_c     (wr_c),
        .op_code  (op_code),
        .mat_size (mat_size),
        .go       (go),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .link_out (link_out),
        .link_in  (link_in)
    );

    int total = 0;
    int bad = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Model: operands as written by the bench and the job configuration.
    int m_a [N], m_b [N], m_c [N];
    int job_op = 0, job_sz = 0;

    // Responder state.
    int r_a [N], r_b [N], r_c [N], r_op [N], r_sz [N];
    int wr_cnt = 0, rd_cnt = 0, phase = 0, dly = 0;
    int max_dly = 0, hang_elem = -1;
    int t_wr_end = 0, gap = 0, t_hang = 0;
    bit is_wr = 1'b0;

    function automatic int f_res(int a, int b, int c, int op, int sz);
        return (b + c - 4 * a + 100 + op - 3 + 16 * (sz - 2)) & 255;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    always begin
        @(posedge clk);
        #1;
        if (reset || link_out[29]) begin
            link_in = '0;
            phase = 0;
            wr_cnt = 0;
            rd_cnt = 0;
        end else begin
            case (phase)
                0: if (link_out[31]) begin
                    is_wr = (wr_cnt < N);
                    if (is_wr) begin
                        r_a[wr_cnt]  = int'(link_out[7:0]);
                        r_b[wr_cnt]  = int'(link_out[15:8]);
                        r_c[wr_cnt]  = int'(link_out[28:21]);
                        r_op[wr_cnt] = int'(link_out[18:16]);
                        r_sz[wr_cnt] = int'(link_out[20:19]);
                    end else if (rd_cnt == 0) begin
                        gap = cyc - t_wr_end;
                    end
                    if (is_wr && wr_cnt == hang_elem) begin
                        t_hang = cyc;
                        phase = 4;
                    end else begin
                        dly = $urandom_range(max_dly, 0);
                        phase = 1;
                    end
                end
                1: if (dly == 0) begin
                    link_in[31] = 1'b1;
                    link_in[30:8] = 23'h5a5a5;
                    if (!is_wr)
                        link_in[7:0] = (rd_cnt < N) ?
                            8'(f_res(r_a[rd_cnt], r_b[rd_cnt], r_c[rd_cnt],
                                     r_op[rd_cnt], r_sz[rd_cnt])) : 8'hee;
                    phase = 2;
                end else dly--;
                2: if (!link_out[31]) begin
                    dly = $urandom_range(max_dly, 0);
                    phase = 3;
                end
                3: if (dly == 0) begin
                    link_in[31] = 1'b0;
                    if (is_wr) begin
                        wr_cnt++;
                        if (wr_cnt == N) t_wr_end = cyc;
                    end else rd_cnt++;
                    phase = 0;
                end else dly--;
                default: ;
            endcase
        end
    end

    // Per-cycle compare against the model.
    int srst_run = 0, start_run = 0;
    always @(negedge clk) begin
        if (!reset) begin
            if (wr_cnt < N && (link_out[31] || phase inside {1, 2, 3})) begin
                logic [31:0] e;
                e = ((m_c[wr_cnt] & 255) << 21) | ((job_sz & 3) << 19) |
                    ((job_op & 7) << 16) | ((m_b[wr_cnt] & 255) << 8) |
                    (m_a[wr_cnt] & 255);
                e[31] = link_out[31];
                chk("wr_fields", {1'b0, link_out[30:0]}, {1'b0, e[30:0]});
            end
            if (wr_cnt == N && link_out[31])
                chk("rd_req_word", {1'b0, link_out[30:0]}, 32'd0);
            if (link_out[30]) begin
                start_run++;
                chk("start_ctx",
                    32'(srst_run == SC && start_run <= SC &&
                        !link_out[31] && !link_out[29]), 32'd1);
            end else if (link_out[29]) begin
                srst_run++;
                start_run = 0;
            end else begin
                srst_run = 0;
                start_run = 0;
            end
            if (done) chk("done_rd_cnt", rd_cnt, N + 1);
        end
    end

    task automatic load(input int mode);
        for (int i = 0; i < N; i++) begin
            case (mode)
                0: begin m_a[i] = i; m_b[i] = 2 * i; m_c[i] = 3 * i; end
                1: begin
                    m_a[i] = (7 * i + 5) & 255;
                    m_b[i] = (i * i) & 255;
                    m_c[i] = 200 - i;
                end
                default: begin
                    m_a[i] = 255 - i;
                    m_b[i] = 3 * i + 1;
                    m_c[i] = i ^ 90;
                end
            endcase
            @(negedge clk);
            wr_en = 1'b1;
            wr_addr = 5'(i);
            wr_a = 8'(m_a[i]);
            wr_b = 8'(m_b[i]);
            wr_c = 8'(m_c[i]);
        end
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic start_job(input int op, input int sz);
        @(negedge clk);
        op_code = 3'(op);
        mat_size = 2'(sz);
        job_op = op;
        job_sz = sz;
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        chk("busy_on_go", busy, 1);
        chk("err_cleared", err, 0);
        for (int i = 0; i < 2 * SC; i++) begin
            chk("srst_start_seq", link_out[30:29], (i < SC) ? 1 : 2);
            @(negedge clk);
        end
        chk("after_start", link_out[30:29], 0);
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (!done && n < 20000) begin
            @(negedge clk);
            n++;
        end
        if (!done) begin
            chk({tag, "_done_timeout"}, 0, 1);
        end else begin
            chk({tag, "_wr_cnt"}, wr_cnt, N);
            chk({tag, "_err"}, err, 0);
            chk({tag, "_pwait_gap"}, 32'(gap >= PW && gap <= PW + 4), 1);
            @(negedge clk);
            chk({tag, "_done_pulse"}, done, 0);
            chk({tag, "_busy_clr"}, busy, 0);
        end
    endtask

    task automatic check_results(input string tag);
        for (int k = 0; k < N; k++) begin
            rd_addr = 5'(k);
            #1;
            chk(tag, rd_data, f_res(m_a[k], m_b[k], m_c[k], job_op, job_sz));
        end
    endtask

    task automatic rd_lit(input int addr, input int exp);
        rd_addr = 5'(addr);
        #1;
        chk("lit_result", rd_data, exp);
    endtask

    initial begin
        int n;
        bit seen_done;

        repeat (2) @(negedge clk);
        chk("rst_link", link_out, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        reset = 1'b0;

        // Job A: fixed timing, with a stray go and buffer write mid-job.
        load(0);
        max_dly = 0;
        start_job(3, 2);
        @(negedge clk);
        go = 1'b1;
        op_code = 3'd1;
        wr_en = 1'b1;
        wr_addr = 5'd3;
        wr_a = 8'hff;
        wr_b = 8'hff;
        wr_c = 8'hff;
        @(negedge clk);
        go = 1'b0;
        op_code = 3'd3;
        wr_en = 1'b0;
        wait_done("jobA");
        check_results("jobA_res");
        rd_lit(0, 100);
        rd_lit(5, 105);
        rd_lit(24, 124);

        // Job B: random ack delays.
        max_dly = 40;
        start_job(3, 2);
        wait_done("jobB");
        check_results("jobB_res");

        // Job C: responder stalls on element 7.
        max_dly = 0;
        hang_elem = 7;
        start_job(3, 2);
        n = 0;
        seen_done = 1'b0;
        while (!err && n < TO + 2000) begin
            @(negedge clk);
            if (done) seen_done = 1'b1;
            n++;
        end
        chk("to_err", err, 1);
        chk("to_elapsed", 32'(cyc - t_hang >= TO && cyc - t_hang <= TO + 4), 1);
        chk("to_busy", busy, 0);
        chk("to_link", link_out, 0);
        chk("to_no_done", seen_done, 0);
        hang_elem = -1;

        // Job D: reset during read handshake 10, then rerun.
        max_dly = 5;
        start_job(3, 2);
        n = 0;
        while (!(rd_cnt == 10 && link_out[31]) && n < 20000) begin
            @(negedge clk);
            n++;
        end
        chk("reach_rd10", rd_cnt, 10);
        reset = 1'b1;
        #1;
        chk("mid_rst_link", link_out, 0);
        chk("mid_rst_busy", busy, 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        start_job(3, 2);
        wait_done("jobD");
        check_results("jobD_res");

        // Jobs E/F: back-to-back with different operands.
        max_dly = 3;
        load(1);
        start_job(5, 1);
        wait_done("jobE");
        check_results("jobE_res");
        rd_lit(2, 212);
        load(2);
        start_job(6, 3);
        wait_done("jobF");
        check_results("jobF_res");
        rd_lit(1, 222);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/hps_link_master.md
HPS_LINK_MASTER -- requirements
Module: hps_link_master

Interface
REQ-001 Parameter PROC_WAIT, default 64: idle cycles between the last write handshake and the first read handshake.
REQ-002 Parameter ACK_TIMEOUT, default 1024: maximum cycles spent waiting for any single ack transition.
REQ-003 Parameter SRST_CYC, default 4: number of cycles the link soft-reset bit is held; the same count applies to the start bit.
REQ-004 clk  in  1  clock; reset reset, asynchronous, active-high; clock clk.
REQ-005 reset  in  1  asynchronous active-high reset.
REQ-006 wr_en  in  1  operand buffer write strobe; wr_addr in 5, wr_a/wr_b/wr_c in 8 each: element index and operand values.
REQ-007 op_code  in  3 and mat_size  in  2: job configuration, sampled on go.
REQ-008 go  in  1  single-cycle job start; busy  out  1: job in progress.
REQ-009 done  out  1  one-cycle pulse on success; err  out  1: sticky timeout flag, cleared by go.
REQ-010 rd_addr  in  5 and rd_data  out  8: combinational read of the result buffer.
REQ-011 link_out  out  32  word driven to the responder: [7:0] a, [15:8] b, [18:16] op_code, [20:19] size, [28:21] c, [29] soft reset, [30] start, [31] ready.
REQ-012 link_in  in  32  word returned by the responder: [31] ack, [7:0] result byte; all other bits ignored.

Function
REQ-013 Buffers SHALL hold 25 operand entries of 24 bits (a, b, c) and 25 result entries of 8 bits; wr_en is ignored while busy.
REQ-014 link_in[31] SHALL pass through a 2-flop synchronizer before use; link_in[7:0] is sampled only when the synchronized ack is stable.
REQ-015 FSM states: IDLE, SRST, START, W_SETUP, W_REQ, W_REL, PWAIT, R_REQ, R_REL, FIN, ERR.
REQ-016 IDLE: on go, latch op_code and mat_size, clear err, clear idx, assert busy, go to SRST; go while busy is ignored.
REQ-017 SRST: link_out[29]=1 for SRST_CYC cycles, then go to START.
REQ-018 START: link_out[30]=1 for SRST_CYC cycles with ready=0, then go to W_SETUP; start SHALL be 0 in every other state.
REQ-019 W_SETUP: drive element idx fields with ready=0 for one cycle, then go to W_REQ; the data fields SHALL stay stable until W_REL exits.
REQ-020 W_REQ: ready=1 until sync ack=1, then go to W_REL.
REQ-021 W_REL: ready=0 until sync ack=0; then if idx==24, clear idx and go to PWAIT; otherwise increment idx and go to W_SETUP.
REQ-022 PWAIT: ready=0 for PROC_WAIT cycles, then go to R_REQ; ready SHALL never rise while the responder may still be processing.
REQ-023 R_REQ: ready=1 until sync ack=1, then go to R_REL.
REQ-024 R_REL: ready=0 until sync ack=0; on that cycle capture link_in[7:0] into result[idx] if idx<=24.
REQ-025 R_REL exit: if idx==25, go to FIN; otherwise increment idx and go to R_REQ. Exactly 26 read handshakes occur, and the 26th byte is discarded.
REQ-026 FIN: pulse done for one cycle, clear busy, go to IDLE.
REQ-027 Timeout: a wait counter resets on every entry to W_REQ, W_REL, R_REQ or R_REL.
REQ-028 When the wait counter reaches ACK_TIMEOUT, the FSM SHALL go to ERR.
REQ-029 ERR: set err, drive link_out to all zeros, clear busy, go to IDLE without a done pulse.
REQ-030 link_out SHALL be registered; bits the current state does not drive are 0.

Reset
REQ-031 On reset: state=IDLE, link_out=0, busy=0, done=0, err=0, idx=0, synchronizer flops=0.
REQ-032 Buffer contents are not reset.
REQ-033 Reset mid-job SHALL abort immediately; the next job's SRST phase resynchronizes the responder.

Structure
REQ-034 Shared package link_pkg SHALL hold the link_out and link_in field bit positions, the element count (25) and the state encoding.
REQ-035 One sub-module, link_sync2 (2-flop synchronizer), SHALL be instantiated for link_in[31].

Verification
REQ-036 Operand entries a=i, b=2i, c=3i (i=0..24), op_code=3, mat_size=2, go; bench responder returns result[k]=k+100 -> done after 25 writes and 26 reads, rd_data at address k = k+100, err=0.
REQ-037 Responder delays each ack by 0..40 random cycles -> identical results; the data fields stay unchanged from W_SETUP until ack falls.
REQ-038 Responder never raises ack on element 7 -> err=1 after ACK_TIMEOUT cycles, busy=0, link_out=0, no done pulse.
REQ-039 Assert reset during read handshake 10, deassert it, then go -> link_out shows bit 29 high for 4 cycles, then bit 30 high for 4 cycles; the full job completes correctly.
REQ-040 Issue go while busy, and wr_en to address 3 with a=0xFF mid-job -> both ignored; results match the original operands.
REQ-041 Issue two back-to-back jobs with different operands -> second results reflect only the second operands; start is never high outside START.
